// File: rtl/syscall_pkg.sv
// Shared constants, FSM state type and character helpers for the syscall console.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_a  = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_x  = 8'h78;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_HALTED
  } state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_a + {4'h0, n} - 8'd10);
  endfunction

  // Digit d counts from the most-significant nibble.
  function automatic logic [3:0] nibble_sel(input logic [31:0] w, input logic [2:0] d);
    return w[5'd31 - {d, 2'b00} -: 4];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter: start pulse loads a 10-bit frame, done strobes in the last stop-bit cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [9:0]    shreg_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic          active_q;

  // Line level is always shreg_q[0]; ones shift in so the line idles high.
  assign tx_o   = shreg_q[0];
  assign done_o = active_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else if (!active_q) begin
      if (start_i) begin
        shreg_q  <= {1'b1, data_i, 1'b0};
        baud_q   <= '0;
        bit_q    <= '0;
        active_q <= 1'b1;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_q  <= '0;
      shreg_q <= {1'b1, shreg_q[9:1]};
      if (bit_q == 4'd9) active_q <= 1'b0;
      else               bit_q    <= bit_q + 4'd1;
    end else begin
      baud_q <= baud_q + BW'(1);
    end
  end

endmodule

// File: rtl/syscall_console.sv
// MIPS syscall snapshot to UART console: print int (hex), print char, exit.
// Define SYSCALL_HEX_PREFIX_EN to prefix printed integers with "0x".
module syscall_console
  import syscall_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sys_valid,
  output logic             sys_ready,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  output logic             tx,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] char_count
);

`ifdef SYSCALL_HEX_PREFIX_EN
  localparam logic [3:0] INT_LAST = 4'd10;
`else
  localparam logic [3:0] INT_LAST = 4'd8;
`endif

  state_e           state_q;
  logic [31:0]      v0_q, a0_q;
  logic [3:0]       idx_q;
  logic             busy_q, halted_q, ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic       is_int, is_char, tx_start, tx_done;
  logic [3:0] last_idx;
  logic [7:0] cur_char;

  assign is_int   = (v0_q == SYS_PRINT_INT);
  assign is_char  = (v0_q == SYS_PRINT_CHAR);
  assign last_idx = is_int ? INT_LAST : 4'd0;
  assign tx_start = (state_q == ST_LOAD) && (is_int || is_char);

  always_comb begin
    cur_char = a0_q[7:0];
    if (is_int) begin
`ifdef SYSCALL_HEX_PREFIX_EN
      if      (idx_q == 4'd0)     cur_char = ASCII_0;
      else if (idx_q == 4'd1)     cur_char = ASCII_x;
      else if (idx_q == INT_LAST) cur_char = ASCII_LF;
      else cur_char = hex_ascii(nibble_sel(a0_q, 3'(idx_q - 4'd2)));
`else
      if (idx_q == INT_LAST) cur_char = ASCII_LF;
      else cur_char = hex_ascii(nibble_sel(a0_q, idx_q[2:0]));
`endif
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start_i(tx_start),
    .data_i (cur_char),
    .tx_o   (tx),
    .done_o (tx_done)
  );

  // Print codes raise busy on the accepting edge; the code is fully decoded in LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      v0_q     <= '0;
      a0_q     <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (sys_valid && ready_q) begin
            v0_q    <= v0;
            a0_q    <= a0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= (v0 == SYS_PRINT_INT) || (v0 == SYS_PRINT_CHAR);
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (is_int || is_char) begin
            state_q <= ST_SEND;
          end else if (v0_q == SYS_EXIT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (tx_done) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          idx_q <= idx_q + 4'd1;
          if (idx_q == last_idx) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign sys_ready  = ready_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_syscall_console.sv
// Scoreboard bench for syscall_console: stimulus pushes expected bytes, a UART monitor pops and compares.
module tb_syscall_console;
  localparam int C  = 4;
  localparam int CW = 16;
`ifdef SYSCALL_HEX_PREFIX_EN
  localparam int NINT = 11;
`else
  localparam int NINT = 9;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sys_valid = 1'b0;
  logic [31:0]   v0 = '0;
  logic [31:0]   a0 = '0;
  logic          sys_ready, tx, busy, halted;
  logic [CW-1:0] char_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  syscall_console #(.CLKS_PER_BIT(C), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sys_valid (sys_valid),
    .sys_ready (sys_ready),
    .v0        (v0),
    .a0        (a0),
    .tx        (tx),
    .busy      (busy),
    .halted    (halted),
    .char_count(char_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns 1ns after the edge that may accept the request.
  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    sys_valid = 1'b1; v0 = code; a0 = arg;
    @(posedge clk); #1;
    sys_valid = 1'b0; v0 = 32'd1; a0 = 32'hFFFF_FFFF;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (sys_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, sys_ready}, 32'd1);
  endtask

  task automatic push_int_deadbeef();
`ifdef SYSCALL_HEX_PREFIX_EN
    expq.push_back(8'h30); expq.push_back(8'h78);
`endif
    expq.push_back(8'h64); expq.push_back(8'h65); expq.push_back(8'h61);
    expq.push_back(8'h64); expq.push_back(8'h62); expq.push_back(8'h65);
    expq.push_back(8'h65); expq.push_back(8'h66); expq.push_back(8'h0A);
  endtask

  // UART receiver: checks every cycle of each bit, framing, and the expected byte.
  initial begin : monitor
    logic [9:0] bits;
    logic       hold_bad, aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        bits = '0; hold_bad = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 10 && !aborted; k++)
          for (int j = 0; j < C && !aborted; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (rst !== 1'b1)      aborted = 1'b1;
            else if (j == 0)       bits[k] = tx;
            else if (tx !== bits[k]) hold_bad = 1'b1;
          end
        if (!aborted) begin
          chk("bit_hold", {31'd0, hold_bad}, 32'd0);
          chk("stop_bit", {31'd0, bits[9]}, 32'd1);
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_char: got %02h expected none", bits[8:1]);
          end else begin
            chk("char", {24'd0, bits[8:1]}, {24'd0, expq.pop_front()});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [CW-1:0] cnt0;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_cnt", {16'd0, char_count}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_ready", {31'd0, sys_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b1;
    #1 chk("ready_pre_edge", {31'd0, sys_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_rst", {31'd0, sys_ready}, 32'd1);

    // Print char 'A'
    expq.push_back(8'h41);
    issue(32'd11, 32'h0000_0041);
    @(negedge clk);
    chk("char_load_tx", {31'd0, tx}, 32'd1);
    chk("char_load_busy", {31'd0, busy}, 32'd1);
    chk("char_load_ready", {31'd0, sys_ready}, 32'd0);
    @(negedge clk);
    chk("char_start_bit", {31'd0, tx}, 32'd0);
    cycles(40);
    chk("char_busy_next", {31'd0, busy}, 32'd1);
    chk("char_cnt_next", {16'd0, char_count}, 32'd0);
    @(negedge clk);
    chk("char_busy_done", {31'd0, busy}, 32'd0);
    chk("char_ready_done", {31'd0, sys_ready}, 32'd1);
    chk("char_cnt", {16'd0, char_count}, 32'd1);

    // Print int 0xDEADBEEF
    push_int_deadbeef();
    issue(32'd1, 32'hDEAD_BEEF);
    cycles(2);
    chk("int_start_bit", {31'd0, tx}, 32'd0);
    cycles(NINT * 42 - 2);
    chk("int_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("int_busy_done", {31'd0, busy}, 32'd0);
    chk("int_ready_done", {31'd0, sys_ready}, 32'd1);
    chk("int_cnt", {16'd0, char_count}, 32'(1 + NINT));
    chk("int_queue", 32'(expq.size()), 32'd0);

    // Second request mid-frame is dropped
    expq.push_back(8'h43);
    issue(32'd11, 32'h0000_0043);
    cycles(10);
    chk("mid_ready", {31'd0, sys_ready}, 32'd0);
    issue(32'd11, 32'h0000_0042);
    wait_idle(100);
    cycles(60);
    chk("drop_cnt", {16'd0, char_count}, 32'(2 + NINT));
    chk("drop_queue", 32'(expq.size()), 32'd0);

    // Unknown code
    cnt0 = char_count;
    issue(32'd5, 32'h0000_0055);
    @(negedge clk);
    chk("unk_ready_low", {31'd0, sys_ready}, 32'd0);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("unk_ready_back", {31'd0, sys_ready}, 32'd1);
    cycles(45);
    chk("unk_cnt", {16'd0, char_count}, {16'd0, cnt0});

    // Exit, then a print that must be ignored
    issue(32'd10, 32'h0);
    @(negedge clk);
    chk("exit_halted_pre", {31'd0, halted}, 32'd0);
    @(negedge clk);
    chk("exit_halted", {31'd0, halted}, 32'd1);
    chk("exit_ready", {31'd0, sys_ready}, 32'd0);
    issue(32'd11, 32'h0000_0044);
    cycles(50);
    chk("halt_ready", {31'd0, sys_ready}, 32'd0);
    chk("halt_tx", {31'd0, tx}, 32'd1);
    chk("halt_cnt", {16'd0, char_count}, {16'd0, cnt0});

    // Reset clears halt; then reset in the 4th data bit of a print int
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_ready", {31'd0, sys_ready}, 32'd1);
    push_int_deadbeef();
    issue(32'd1, 32'hDEAD_BEEF);
    cycles(18);
    rst = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cnt", {16'd0, char_count}, 32'd0);
    expq.delete();
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, sys_ready}, 32'd1);
    expq.push_back(8'h5A);
    issue(32'd11, 32'h0000_005A);
    wait_idle(100);
    chk("fresh_cnt", {16'd0, char_count}, 32'd1);
    cycles(20);
    chk("final_queue", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
